// File: rtl/vga_capture_if.sv
// Video input, capture control and byte-write memory bus for vga_capture.
// The master drives video/start/wr_ready; the slave (vga_capture) drives writes and status.
interface vga_capture_if;
    logic        pix_en;
    logic        de;
    logic        vsync;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        start;
    logic        we;
    logic [31:0] address;
    logic [7:0]  wd;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    modport master (
        output pix_en, de, vsync, r, g, b, start, wr_ready,
        input  we, address, wd, busy, done, overflow
    );

    modport slave (
        input  pix_en, de, vsync, r, g, b, start, wr_ready,
        output we, address, wd, busy, done, overflow
    );
endinterface

// File: rtl/vga_capture.sv
// Single-frame window capture into byte memory; pixel reaches the bus 2 clks after push.
// Writes hold while wr_ready=0; pixels arriving with the FIFO full are dropped and flagged.
module vga_capture #(
    parameter int WIN_W       = 100,
    parameter int WIN_H       = 100,
    parameter int LINE_STRIDE = 300,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic         clk,
    input  logic         reset,
    vga_capture_if.slave bus
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [9:0]    WIN_W_L = 10'(WIN_W);
    localparam logic [9:0]    WIN_H_L = 10'(WIN_H);

    typedef struct packed {
        logic [31:0] base;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } pix_t;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} cap_state_t;
    typedef enum logic [1:0] {W_IDLE, W_R, W_G, W_B} wr_state_t;

    cap_state_t  cap_state_q, cap_state_d;
    wr_state_t   wr_state_q, wr_state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        de_last_q, de_last_d;
    logic        vsync_last_q, vsync_last_d;
    logic        overflow_q, overflow_d;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    pix_t        cur_q, cur_d;
    pix_t        mem [FIFO_DEPTH];

    logic        empty, full, vsync_fall, push_req, push, pop, done;
    logic        we;
    logic [31:0] address;
    logic [7:0]  wd;
    pix_t        pix_in;

    always_comb begin
        empty        = (wptr_q == rptr_q);
        full         = ((wptr_q - rptr_q) == DEPTH_L);
        vsync_fall   = vsync_last_q & ~bus.vsync;
        vsync_last_d = bus.vsync;
        push_req     = (cap_state_q == CAPTURE) && bus.pix_en && bus.de &&
                       (x_q < WIN_W_L) && (y_q < WIN_H_L);
        // Fullness is judged on this cycle's pointers, so a same-cycle pop never makes room.
        push         = push_req && !full;
        pix_in.base  = 32'(y_q) * 32'(LINE_STRIDE) + 32'(x_q) * 32'd3;
        pix_in.r     = bus.r;
        pix_in.g     = bus.g;
        pix_in.b     = bus.b;
    end

    // Capture FSM and window position tracking.
    always_comb begin
        cap_state_d = cap_state_q;
        x_d         = x_q;
        y_d         = y_q;
        de_last_d   = de_last_q;
        overflow_d  = overflow_q;
        done        = 1'b0;
        case (cap_state_q)
            IDLE: begin
                if (bus.start) begin
                    cap_state_d = ARMED;
                    overflow_d  = 1'b0;
                end
            end
            ARMED: begin
                if (vsync_fall) begin
                    cap_state_d = CAPTURE;
                    x_d         = '0;
                    y_d         = '0;
                    de_last_d   = 1'b0;
                end
            end
            CAPTURE: begin
                if (bus.pix_en) begin
                    de_last_d = bus.de;
                    if (bus.de) begin
                        x_d = (x_q == 10'd1023) ? x_q : x_q + 10'd1;
                    end else if (de_last_q) begin
                        x_d = '0;
                        y_d = y_q + 10'd1;
                    end
                end
                if ((y_q == WIN_H_L) || vsync_fall) cap_state_d = DRAIN;
            end
            DRAIN: begin
                if (empty && (wr_state_q == W_IDLE)) begin
                    cap_state_d = IDLE;
                    done        = 1'b1;
                end
            end
            default: cap_state_d = IDLE;
        endcase
        if (push_req && full) overflow_d = 1'b1;
    end

    // Write FSM: one popped pixel becomes three byte writes, R then G then B.
    always_comb begin
        wr_state_d = wr_state_q;
        cur_d      = cur_q;
        pop        = 1'b0;
        we         = 1'b0;
        address    = '0;
        wd         = '0;
        case (wr_state_q)
            W_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cur_d      = mem[rptr_q[AW-1:0]];
                    wr_state_d = W_R;
                end
            end
            W_R: begin
                we      = 1'b1;
                address = cur_q.base;
                wd      = cur_q.r;
                if (bus.wr_ready) wr_state_d = W_G;
            end
            W_G: begin
                we      = 1'b1;
                address = cur_q.base + 32'd1;
                wd      = cur_q.g;
                if (bus.wr_ready) wr_state_d = W_B;
            end
            W_B: begin
                we      = 1'b1;
                address = cur_q.base + 32'd2;
                wd      = cur_q.b;
                if (bus.wr_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        cur_d      = mem[rptr_q[AW-1:0]];
                        wr_state_d = W_R;
                    end else begin
                        wr_state_d = W_IDLE;
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = pop  ? rptr_q + PTR_ONE : rptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_state_q  <= IDLE;
            wr_state_q   <= W_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            de_last_q    <= 1'b0;
            vsync_last_q <= 1'b1;
            overflow_q   <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cur_q        <= '0;
        end else begin
            cap_state_q  <= cap_state_d;
            wr_state_q   <= wr_state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            de_last_q    <= de_last_d;
            vsync_last_q <= vsync_last_d;
            overflow_q   <= overflow_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cur_q        <= cur_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= pix_in;
    end

    assign bus.we       = we;
    assign bus.address  = address;
    assign bus.wd       = wd;
    assign bus.busy     = (cap_state_q != IDLE);
    assign bus.done     = done;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture: table of frame scenarios scored against an
// expected-write queue built from the window rules, plus reset and overflow sequences.
module tb_vga_capture;
    localparam int W      = 10;
    localparam int H      = 6;
    localparam int STRIDE = 40;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_capture_if vif();

    vga_capture #(
        .WIN_W(W), .WIN_H(H), .LINE_STRIDE(STRIDE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(vif.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        int lines;
        int lw;
        int per;
        int rmode;
        bit hold;
        bit mid;
        bit pat;
        int exp_wr;
        bit exp_ovf;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   nwrites = 0;
    int   ndone = 0;
    int   rmode = 0;
    logic man_ready = 1'b0;
    bit   sb_en = 1'b1;
    wr_t  exp_q[$];
    wr_t  e;
    bit   stall_prev = 1'b0;
    logic [31:0] stall_a;
    logic [7:0]  stall_d;
    logic [7:0]  cr [24][24];
    logic [7:0]  cg [24][24];
    logic [7:0]  cb [24][24];
    vec_t vecs [5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wr_ready pattern generator; runs 2 units after the edge so mode changes land cleanly
    initial begin
        vif.wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0: vif.wr_ready = 1'b1;
                1: vif.wr_ready = ~vif.wr_ready;
                2: vif.wr_ready = ($urandom_range(3) != 0);
                3: vif.wr_ready = 1'b0;
                default: vif.wr_ready = man_ready;
            endcase
        end
    end

    // Bus monitor: scores accepted writes and checks stability during stalls
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_we", vif.we, 1);
                    check("stall_addr", vif.address, stall_a);
                    check("stall_wd", vif.wd, stall_d);
                end
                stall_prev = vif.we && !vif.wr_ready;
                stall_a    = vif.address;
                stall_d    = vif.wd;
                if (vif.we && vif.wr_ready) begin
                    nwrites++;
                    if (sb_en) begin
                        if (exp_q.size() == 0) begin
                            check("extra_write", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("wr_addr", vif.address, e.a);
                            check("wr_data", vif.wd, e.d);
                        end
                    end
                end
                if (vif.done) ndone++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        vif.start = 1'b1;
        tick();
        vif.start = 1'b0;
    endtask

    task automatic vsync_fall();
        vif.vsync = 1'b0;
        repeat (3) tick();
        vif.vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && vif.busy; i++) tick();
        tick();
    endtask

    task automatic run_frame(input vec_t v);
        int n0 = nwrites;
        int d0 = ndone;
        int ny = (v.lines < H) ? v.lines : H;
        int nx = (v.lw < W) ? v.lw : W;
        exp_q.delete();
        for (int yy = 0; yy < 24; yy++) begin
            for (int xx = 0; xx < 24; xx++) begin
                cr[yy][xx] = v.pat ? 8'(xx) : 8'($urandom);
                cg[yy][xx] = v.pat ? 8'(yy) : 8'($urandom);
                cb[yy][xx] = v.pat ? 8'(xx ^ yy) : 8'($urandom);
            end
        end
        for (int yy = 0; yy < ny; yy++) begin
            for (int xx = 0; xx < nx; xx++) begin
                // A stalled writer holds one pixel while the FIFO holds DEPTH more.
                if (!(v.hold && yy == 0 && xx > DEPTH)) begin
                    exp_q.push_back('{32'(yy * STRIDE + xx * 3),     cr[yy][xx]});
                    exp_q.push_back('{32'(yy * STRIDE + xx * 3 + 1), cg[yy][xx]});
                    exp_q.push_back('{32'(yy * STRIDE + xx * 3 + 2), cb[yy][xx]});
                end
            end
        end
        rmode = v.rmode;
        sb_en = 1'b1;
        tick();
        pulse_start();
        vsync_fall();
        for (int yy = 0; yy < v.lines; yy++) begin
            for (int px = 0; px < v.lw + 4; px++) begin
                vif.pix_en = 1'b1;
                vif.de     = (px < v.lw);
                vif.r      = cr[yy][px];
                vif.g      = cg[yy][px];
                vif.b      = cb[yy][px];
                vif.start  = v.mid && (yy == 1) && (px == 2);
                tick();
                vif.pix_en = 1'b0;
                vif.start  = 1'b0;
                if (v.hold && yy == 0 && px == v.lw) rmode = 0;
                repeat (v.per - 1) tick();
            end
        end
        vsync_fall();
        wait_idle();
        check("writes", nwrites - n0, v.exp_wr);
        check("queue_left", exp_q.size(), 0);
        check("done_pulses", ndone - d0, 1);
        check("overflow", vif.overflow, v.exp_ovf);
        check("busy_end", vif.busy, 0);
    endtask

    initial begin
        int n0;
        vec_t fin;
        vif.pix_en = 1'b0;
        vif.de     = 1'b0;
        vif.vsync  = 1'b1;
        vif.r      = '0;
        vif.g      = '0;
        vif.b      = '0;
        vif.start  = 1'b0;

        //          lines lw per rmode hold mid pat exp_wr ovf
        vecs[0] = '{8, 14, 4, 0, 1'b0, 1'b0, 1'b1, 180, 1'b0};
        vecs[1] = '{8, 14, 8, 1, 1'b0, 1'b0, 1'b0, 180, 1'b0};
        vecs[2] = '{3,  7, 4, 0, 1'b0, 1'b1, 1'b0,  63, 1'b0};
        vecs[3] = '{7, 12, 8, 2, 1'b0, 1'b0, 1'b0, 180, 1'b0};
        vecs[4] = '{1, 12, 2, 3, 1'b1, 1'b0, 1'b0,  27, 1'b1};

        repeat (3) tick();
        check("rst_we", vif.we, 0);
        check("rst_addr", vif.address, 0);
        check("rst_wd", vif.wd, 0);
        check("rst_busy", vif.busy, 0);
        check("rst_done", vif.done, 0);
        check("rst_ovf", vif.overflow, 0);
        reset = 1'b0;
        repeat (20) tick();
        check("idle_writes", nwrites, 0);
        check("idle_busy", vif.busy, 0);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        repeat (5) tick();
        check("ovf_sticky", vif.overflow, 1);
        pulse_start();
        check("ovf_cleared", vif.overflow, 0);
        check("armed_busy", vif.busy, 1);

        // Reset in W_G with three pixels still queued
        sb_en     = 1'b0;
        man_ready = 1'b0;
        rmode     = 4;
        tick();
        vsync_fall();
        for (int px = 0; px < 4; px++) begin
            vif.pix_en = 1'b1;
            vif.de     = 1'b1;
            vif.r      = 8'(px);
            tick();
            vif.pix_en = 1'b0;
            tick();
        end
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        #2;
        check("wg_we", vif.we, 1);
        check("wg_addr", vif.address, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_we", vif.we, 0);
        check("mid_rst_addr", vif.address, 0);
        check("mid_rst_busy", vif.busy, 0);
        vif.de = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        rmode = 0;
        n0 = nwrites;
        repeat (40) tick();
        check("post_rst_writes", nwrites - n0, 0);
        check("post_rst_busy", vif.busy, 0);

        fin = '{6, 10, 4, 0, 1'b0, 1'b0, 1'b0, 180, 1'b0};
        run_frame(fin);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
